// File: rtl/exception_sequencer_pkg.sv
// Shared encodings and constants for the interrupt/exception entry sequencer.
package exception_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAVE   = 2'd1,
        ST_KERNEL = 2'd2
    } state_t;

    typedef enum logic {
        CAUSE_IRQ = 1'b0,
        CAUSE_EXC = 1'b1
    } cause_t;

    localparam logic [31:0] DEFAULT_IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0008;
    localparam logic [4:0]  K0_INDEX           = 5'd26;

    // An interrupted instruction must re-execute, so IRQ returns to its own PC;
    // a faulting instruction is skipped, so the exception returns to PC+4.
    function automatic logic [31:0] return_pc(input cause_t cause, input logic [31:0] pc_plus4);
        return (cause == CAUSE_EXC) ? pc_plus4 : (pc_plus4 - 32'd4);
    endfunction

endpackage

// File: rtl/exc_take_logic.sv
// Combinational decision of whether an entry is taken this cycle and for which cause.
import exception_sequencer_pkg::*;

module exc_take_logic (
    input  logic   idle,
    input  logic   id_valid,
    input  logic   pc_write_en,
    input  logic   illegal_op,
    input  logic   irq_req,
    input  logic   branch_taken,
    output logic   take,
    output cause_t cause
);

    logic gate;
    logic exc_take;
    logic irq_take;

    // A redirecting branch would make the IRQ return PC ambiguous, so IRQs wait it out.
    assign gate     = idle & id_valid & pc_write_en;
    assign exc_take = gate & illegal_op;
    assign irq_take = gate & irq_req & ~branch_taken & ~illegal_op;
    assign take     = exc_take | irq_take;
    assign cause    = exc_take ? CAUSE_EXC : CAUSE_IRQ;

endmodule

// File: rtl/exception_sequencer.sv
// Sequences IRQ/exception entry (flush, $k0 save, vector redirect) and kernel-mode exit on eret.
import exception_sequencer_pkg::*;

module exception_sequencer #(
    parameter logic [31:0] IRQ_VECTOR = DEFAULT_IRQ_VECTOR,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_req,
    input  logic        illegal_op,
    input  logic        eret,
    input  logic        id_valid,
    input  logic [31:0] id_pc_plus4,
    input  logic        pc_write_en,
    input  logic        branch_taken,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        k0_we,
    output logic [31:0] k0_wdata,
    output logic        irq_ack,
    output logic        in_kernel,
    output logic        busy
);

    state_t      state_q;
    state_t      state_d;
    cause_t      cause_q;
    cause_t      take_cause;
    logic        take;
    logic [31:0] save_pc_q;

    exc_take_logic u_take (
        .idle         (state_q == ST_IDLE && !reset),
        .id_valid     (id_valid),
        .pc_write_en  (pc_write_en),
        .illegal_op   (illegal_op),
        .irq_req      (irq_req),
        .branch_taken (branch_taken),
        .take         (take),
        .cause        (take_cause)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_IRQ;
            save_pc_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (take) begin
                cause_q   <= take_cause;
                save_pc_q <= return_pc(take_cause, id_pc_plus4);
            end
        end
    end

    // The take cycle is Mealy so the faulting/interrupted instruction never leaves ID.
    always_comb begin
        state_d     = state_q;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        k0_we       = 1'b0;
        k0_wdata    = 32'd0;
        irq_ack     = 1'b0;
        in_kernel   = 1'b0;
        busy        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    state_d     = ST_SAVE;
                end
            end
            ST_SAVE: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                redirect    = 1'b1;
                redirect_pc = (cause_q == CAUSE_EXC) ? EXC_VECTOR : IRQ_VECTOR;
                k0_we       = 1'b1;
                k0_wdata    = save_pc_q;
                irq_ack     = (cause_q == CAUSE_IRQ);
                busy        = 1'b1;
                state_d     = ST_KERNEL;
            end
            ST_KERNEL: begin
                in_kernel = 1'b1;
                busy      = 1'b1;
                if (eret && id_valid && pc_write_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// Scoreboard bench: each stimulus cycle queues its expected outputs, checked at the falling edge.
module tb_exception_sequencer;

    typedef struct packed {
        logic        fif;
        logic        fex;
        logic        redir;
        logic [31:0] rpc;
        logic        kwe;
        logic [31:0] kwd;
        logic        ack;
        logic        ink;
        logic        bsy;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        irq_req;
    logic        illegal_op;
    logic        eret;
    logic        id_valid;
    logic [31:0] id_pc_plus4;
    logic        pc_write_en;
    logic        branch_taken;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        k0_we;
    logic [31:0] k0_wdata;
    logic        irq_ack;
    logic        in_kernel;
    logic        busy;

    int   tests_run;
    int   tests_failed;
    exp_t sb[$];

    exception_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .irq_req      (irq_req),
        .illegal_op   (illegal_op),
        .eret         (eret),
        .id_valid     (id_valid),
        .id_pc_plus4  (id_pc_plus4),
        .pc_write_en  (pc_write_en),
        .branch_taken (branch_taken),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .k0_we        (k0_we),
        .k0_wdata     (k0_wdata),
        .irq_ack      (irq_ack),
        .in_kernel    (in_kernel),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t e_idle();
        return '0;
    endfunction

    function automatic exp_t e_take();
        exp_t e = '0;
        e.fif = 1'b1;
        e.fex = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_save(input logic is_irq, input logic [31:0] pc);
        exp_t e = '0;
        e.fif   = 1'b1;
        e.fex   = 1'b1;
        e.redir = 1'b1;
        e.rpc   = is_irq ? 32'h8000_0004 : 32'h8000_0008;
        e.kwe   = 1'b1;
        e.kwd   = pc;
        e.ack   = is_irq;
        e.bsy   = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_kernel();
        exp_t e = '0;
        e.ink = 1'b1;
        e.bsy = 1'b1;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic irq, input logic ill,
                                 input logic er, input logic v, input logic pwe, input logic br,
                                 input logic [31:0] pc4, input exp_t e);
        exp_t ex;
        reset        = rst;
        irq_req      = irq;
        illegal_op   = ill;
        eret         = er;
        id_valid     = v;
        pc_write_en  = pwe;
        branch_taken = br;
        id_pc_plus4  = pc4;
        sb.push_back(e);
        @(negedge clk);
        ex = sb.pop_front();
        checkOutput({tag, "/flush_if_id"}, {31'd0, flush_if_id}, {31'd0, ex.fif});
        checkOutput({tag, "/flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, ex.fex});
        checkOutput({tag, "/redirect"},    {31'd0, redirect},    {31'd0, ex.redir});
        checkOutput({tag, "/redirect_pc"}, redirect_pc,          ex.rpc);
        checkOutput({tag, "/k0_we"},       {31'd0, k0_we},       {31'd0, ex.kwe});
        checkOutput({tag, "/k0_wdata"},    k0_wdata,             ex.kwd);
        checkOutput({tag, "/irq_ack"},     {31'd0, irq_ack},     {31'd0, ex.ack});
        checkOutput({tag, "/in_kernel"},   {31'd0, in_kernel},   {31'd0, ex.ink});
        checkOutput({tag, "/busy"},        {31'd0, busy},        {31'd0, ex.bsy});
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        irq_req      = 1'b0;
        illegal_op   = 1'b0;
        eret         = 1'b0;
        id_valid     = 1'b0;
        pc_write_en  = 1'b1;
        branch_taken = 1'b0;
        id_pc_plus4  = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        //                       tag          rst irq ill er  v  pwe br  pc4
        applyStimulus("reset",      1, 0, 0, 0, 0, 1, 0, 32'h0,         e_idle());
        applyStimulus("quiet",      0, 0, 0, 0, 1, 1, 0, 32'h100,       e_idle());

        // Plain interrupt entry and return
        applyStimulus("irq_T",      0, 1, 0, 0, 1, 1, 0, 32'h0000_0104, e_take());
        applyStimulus("irq_T1",     0, 1, 0, 0, 0, 1, 0, 32'h0,         e_save(1, 32'h0000_0100));
        applyStimulus("irq_T2",     0, 0, 0, 0, 1, 1, 0, 32'h8000_0008, e_kernel());
        applyStimulus("irq_eret",   0, 0, 0, 1, 1, 1, 0, 32'h8000_000c, e_kernel());
        applyStimulus("irq_back",   0, 0, 0, 0, 1, 1, 0, 32'h104,       e_idle());

        // Gates: bubble, stray eret in IDLE
        applyStimulus("bubble",     0, 1, 1, 0, 0, 1, 0, 32'h110,       e_idle());
        applyStimulus("eret_idle",  0, 0, 0, 1, 1, 1, 0, 32'h114,       e_idle());
        applyStimulus("eret_idle2", 0, 0, 0, 0, 1, 1, 0, 32'h118,       e_idle());

        // Exception entry, no nesting in KERNEL, stalled eret
        applyStimulus("exc_T",      0, 0, 1, 0, 1, 1, 0, 32'h0000_0208, e_take());
        applyStimulus("exc_T1",     0, 0, 0, 0, 0, 1, 0, 32'h0,         e_save(0, 32'h0000_0208));
        applyStimulus("exc_T2",     0, 0, 0, 0, 1, 1, 0, 32'h8000_000c, e_kernel());
        applyStimulus("kern_nest",  0, 1, 1, 0, 1, 1, 0, 32'h8000_0010, e_kernel());
        applyStimulus("kern_stall", 0, 1, 0, 1, 1, 0, 0, 32'h8000_0014, e_kernel());
        applyStimulus("kern_eret",  0, 0, 0, 1, 1, 1, 0, 32'h8000_0014, e_kernel());
        applyStimulus("exc_back",   0, 0, 0, 0, 1, 1, 0, 32'h20c,       e_idle());

        // Simultaneous IRQ and exception: exception first, IRQ retaken right after return
        applyStimulus("both_T",     0, 1, 1, 0, 1, 1, 0, 32'h0000_0300, e_take());
        applyStimulus("both_T1",    0, 1, 0, 0, 0, 1, 0, 32'h0,         e_save(0, 32'h0000_0300));
        applyStimulus("both_kern",  0, 1, 0, 0, 1, 1, 0, 32'h8000_000c, e_kernel());
        applyStimulus("both_eret",  0, 1, 0, 1, 1, 1, 0, 32'h8000_0010, e_kernel());
        applyStimulus("retake_T",   0, 1, 0, 0, 1, 1, 0, 32'h0000_0304, e_take());
        applyStimulus("retake_T1",  0, 1, 0, 0, 0, 1, 0, 32'h0,         e_save(1, 32'h0000_0300));
        applyStimulus("retake_T2",  0, 0, 0, 0, 1, 1, 0, 32'h8000_0008, e_kernel());
        applyStimulus("retake_eret",0, 0, 0, 1, 1, 1, 0, 32'h8000_000c, e_kernel());
        applyStimulus("retake_back",0, 0, 0, 0, 1, 1, 0, 32'h300,       e_idle());

        // IRQ held off by branch, then by load-use stall; dropping in SAVE keeps entry
        for (int i = 0; i < 3; i++)
            applyStimulus("hold_br",  0, 1, 0, 0, 1, 1, 1, 32'h0000_0500, e_idle());
        for (int i = 0; i < 3; i++)
            applyStimulus("hold_pwe", 0, 1, 0, 0, 1, 0, 0, 32'h0000_0500, e_idle());
        applyStimulus("hold_T",     0, 1, 0, 0, 1, 1, 0, 32'h0000_0500, e_take());
        applyStimulus("hold_T1",    0, 0, 0, 0, 0, 1, 0, 32'h0,         e_save(1, 32'h0000_04fc));
        applyStimulus("hold_T2",    0, 0, 0, 0, 1, 1, 0, 32'h8000_0008, e_kernel());
        applyStimulus("hold_eret",  0, 0, 0, 1, 1, 1, 0, 32'h8000_000c, e_kernel());
        applyStimulus("hold_back",  0, 0, 0, 0, 1, 1, 0, 32'h4fc,       e_idle());

        // Return-PC wraps below zero
        applyStimulus("wrap_T",     0, 1, 0, 0, 1, 1, 0, 32'h0000_0000, e_take());
        applyStimulus("wrap_T1",    0, 0, 0, 0, 0, 1, 0, 32'h0,         e_save(1, 32'hffff_fffc));
        applyStimulus("wrap_T2",    0, 0, 0, 0, 1, 1, 0, 32'h8000_0008, e_kernel());
        applyStimulus("wrap_eret",  0, 0, 0, 1, 1, 1, 0, 32'h8000_000c, e_kernel());
        applyStimulus("wrap_back",  0, 0, 0, 0, 1, 1, 0, 32'h4,         e_idle());

        // Reset while in SAVE aborts the entry
        applyStimulus("rst_T",      0, 0, 1, 0, 1, 1, 0, 32'h0000_0600, e_take());
        applyStimulus("rst_save",   1, 0, 0, 0, 0, 1, 0, 32'h0,         e_save(0, 32'h0000_0600));
        applyStimulus("rst_after",  0, 0, 0, 0, 0, 1, 0, 32'h0,         e_idle());
        applyStimulus("rst_after2", 0, 0, 0, 0, 1, 1, 0, 32'h604,       e_idle());

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
